// File: rtl/rr_stream_mux_pkg.sv
// rr_stream_mux_pkg
//   Shared helpers for the round-robin stream merger.
//   chan_w(n)   : width of a channel tag, max(1, clog2(n))
//   level_w(d)  : width of a 0..d occupancy count, clog2(d+1)
//   MAX_CHANNELS, MIN_DEPTH : legal parameter limits
package rr_stream_mux_pkg;

    localparam int MAX_CHANNELS = 16;
    localparam int MIN_DEPTH    = 2;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int level_w(input int d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// rr_stream_mux_if
//   Bundles the input-side and output-side valid/ready streams of
//   rr_stream_mux.
//   master : producer/consumer side (drives i_valid, i_data, o_ready)
//   slave  : merger side (drives i_ready, o_valid, o_data, o_chan)
//   Signals:
//     i_valid[CHANNELS], i_ready[CHANNELS], i_data[CHANNELS*WIDTH]
//     o_valid, o_ready, o_data[WIDTH], o_chan[chan_w(CHANNELS)]
//   With RR_STREAM_MUX_LEVEL_EN defined the interface also carries
//   o_level, o_full and o_stall_seen and takes a DEPTH parameter.
interface rr_stream_mux_if
    import rr_stream_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
`ifdef RR_STREAM_MUX_LEVEL_EN
    ,
    parameter int DEPTH    = 4
`endif
);

    localparam int CW = chan_w(CHANNELS);

    logic [CHANNELS-1:0]       i_valid;
    logic [CHANNELS-1:0]       i_ready;
    logic [CHANNELS*WIDTH-1:0] i_data;
    logic                      o_valid;
    logic                      o_ready;
    logic [WIDTH-1:0]          o_data;
    logic [CW-1:0]             o_chan;

`ifdef RR_STREAM_MUX_LEVEL_EN
    localparam int LW = level_w(DEPTH);

    logic [LW-1:0]             o_level;
    logic                      o_full;
    logic                      o_stall_seen;

    modport master (
        output i_valid, i_data, o_ready,
        input  i_ready, o_valid, o_data, o_chan, o_level, o_full, o_stall_seen
    );

    modport slave (
        input  i_valid, i_data, o_ready,
        output i_ready, o_valid, o_data, o_chan, o_level, o_full, o_stall_seen
    );
`else
    modport master (
        output i_valid, i_data, o_ready,
        input  i_ready, o_valid, o_data, o_chan
    );

    modport slave (
        input  i_valid, i_data, o_ready,
        output i_ready, o_valid, o_data, o_chan
    );
`endif

endinterface

// File: rtl/rr_stream_mux_fifo.sv
// rr_stream_mux_fifo
//   DEPTH-entry, DW-bit FIFO with registered count and full flag.
//   DEPTH need not be a power of two; pointers wrap explicitly.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     push_i     : write wdata_i at the write pointer (caller ensures !full)
//     pop_i      : advance the read pointer (caller ensures count != 0)
//     wdata_i    : word to store
//     rdata_o    : head entry, read combinationally; zero when empty
//     count_o    : number of stored words
//     full_o     : registered (count == DEPTH)
//   Storage is not reset; only pointers, count and full are.
module rr_stream_mux_fifo
    import rr_stream_mux_pkg::*;
#(
    parameter int DW    = 10,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [DW-1:0]             wdata_i,
    output logic [DW-1:0]             rdata_o,
    output logic [level_w(DEPTH)-1:0] count_o,
    output logic                      full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          full_q, full_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        if (push_i) begin
            wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (pop_i) begin
            rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        end

        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        full_d = (count_d == LW'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = (count_q == '0) ? '0 : mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = full_q;

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux
//   Merges CHANNELS valid/ready input streams into one output stream
//   through a DEPTH-entry FIFO. A round-robin arbiter picks the next
//   channel starting after the last accepted one; each stored word is
//   tagged with its source channel.
//   Ports:
//     clk  : clock, all state on the rising edge
//     rst  : asynchronous active-high reset
//     bus  : rr_stream_mux_if.slave
//            i_valid/i_ready/i_data : per-channel input streams
//            o_valid/o_ready/o_data/o_chan : merged, tagged output
//   Optional feature macro: RR_STREAM_MUX_LEVEL_EN
//     adds o_level (current count), o_full (count == DEPTH) and a sticky
//     o_stall_seen (an input was valid while the FIFO had no space).
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4
) (
    input  logic           clk,
    input  logic           rst,
    rr_stream_mux_if.slave bus
);

    localparam int CW = chan_w(CHANNELS);
    localparam int LW = level_w(DEPTH);

    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_channels
        $error("rr_stream_mux: CHANNELS out of range");
    end
    if (DEPTH < MIN_DEPTH) begin : g_bad_depth
        $error("rr_stream_mux: DEPTH below minimum");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("rr_stream_mux: WIDTH below minimum");
    end

    logic [CW-1:0]       last_grant_q, last_grant_d;
    logic [CW-1:0]       grant_c;
    logic                grant_found_c;
    logic                space_c;
    logic                push_c;
    logic                pop_c;
    logic                valid_c;
    logic [CHANNELS-1:0] ready_c;
    logic [WIDTH-1:0]    wdata_c;
    logic [CW+WIDTH-1:0] fifo_wdata;
    logic [CW+WIDTH-1:0] fifo_rdata;
    logic [LW-1:0]       count;
    logic                full;

    // Registered full flag equals (count == DEPTH), so it is the space test;
    // a pop in the same cycle deliberately does not free a slot.
    assign space_c = !full;

    // Round-robin search: offset i visits channel (last_grant + 1 + i) mod
    // CHANNELS; the inner loop turns that runtime index into constant
    // selects so no variable bit-select of i_valid is needed.
    always_comb begin
        grant_found_c = 1'b0;
        grant_c       = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            int unsigned cand;
            cand = 32'(last_grant_q) + 1 + i;
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                if (!grant_found_c && (k == cand) && bus.i_valid[k]) begin
                    grant_found_c = 1'b1;
                    grant_c       = CW'(k);
                end
            end
        end
    end

    always_comb begin
        ready_c = '0;
        wdata_c = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (CW'(k) == grant_c) begin
                ready_c[k] = grant_found_c && space_c;
                wdata_c    = bus.i_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign push_c       = grant_found_c && space_c;
    assign last_grant_d = push_c ? grant_c : last_grant_q;
    assign fifo_wdata   = {grant_c, wdata_c};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= CW'(CHANNELS - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign valid_c = (count != '0);
    assign pop_c   = valid_c && bus.o_ready;

    rr_stream_mux_fifo #(
        .DW    (CW + WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .count_o (count),
        .full_o  (full)
    );

    assign bus.i_ready = ready_c;
    assign bus.o_valid = valid_c;
    assign bus.o_data  = fifo_rdata[WIDTH-1:0];
    assign bus.o_chan  = fifo_rdata[CW+WIDTH-1 -: CW];

`ifdef RR_STREAM_MUX_LEVEL_EN
    logic stall_seen_q, stall_seen_d;

    assign stall_seen_d = stall_seen_q || ((|bus.i_valid) && !space_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_seen_q <= 1'b0;
        end else begin
            stall_seen_q <= stall_seen_d;
        end
    end

    assign bus.o_level      = count;
    assign bus.o_full       = full;
    assign bus.o_stall_seen = stall_seen_q;
`endif

    // Producers must hold an offered word until it is taken.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_hold_chk
        a_hold: assert property (@(posedge clk) disable iff (rst)
            (bus.i_valid[k] && !bus.i_ready[k]) |=>
            (bus.i_valid[k] && $stable(bus.i_data[k*WIDTH +: WIDTH])));
    end

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(bus.i_ready));

endmodule

// File: tb/tb_rr_stream_mux.sv
module tb_rr_stream_mux;
    import rr_stream_mux_pkg::*;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int D  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

`ifdef RR_STREAM_MUX_LEVEL_EN
    rr_stream_mux_if #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) bus0 ();
    rr_stream_mux_if #(.CHANNELS(1), .WIDTH(W), .DEPTH(3)) bus1 ();
`else
    rr_stream_mux_if #(.CHANNELS(CH), .WIDTH(W)) bus0 ();
    rr_stream_mux_if #(.CHANNELS(1), .WIDTH(W)) bus1 ();
`endif

    rr_stream_mux #(.CHANNELS(CH), .WIDTH(W), .DEPTH(D)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    rr_stream_mux #(.CHANNELS(1), .WIDTH(W), .DEPTH(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    typedef struct packed {
        logic [1:0]   chan;
        logic [W-1:0] data;
    } item_t;

    item_t          sb[$];
    int             checks = 0;
    int             errors = 0;
    int             m_last = CH - 1;
    logic [CH-1:0]  hold = '0;
    logic [CH-1:0]  cur_v = '0;
    logic [CH*W-1:0] cur_d = '0;
    logic [CH-1:0]  last_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the FIFO head against the scoreboard whenever the
    // DUT presents a word; pops when the word is taken downstream.
    always @(negedge clk) begin
        if (!rst) begin
            check("o_valid", {31'd0, bus0.o_valid}, {31'd0, sb.size() != 0});
            if (bus0.o_valid && sb.size() != 0) begin
                check("o_chan", {30'd0, bus0.o_chan}, {30'd0, sb[0].chan});
                check("o_data", {24'd0, bus0.o_data}, {24'd0, sb[0].data});
                if (bus0.o_ready) void'(sb.pop_front());
            end
        end
    end

    // One cycle of stimulus, entered and left at posedge+1. The reference
    // model decides acceptance from the occupancy at the start of the cycle
    // and the rotating search order after the last accepted channel.
    task automatic step(input logic [CH-1:0] nv, input logic [CH*W-1:0] nd, input bit rdy);
        int    occ;
        int    g;
        int    c;
        logic [CH-1:0] exp_ready;
        item_t it;
        for (int k = 0; k < CH; k++) begin
            if (!hold[k]) begin
                cur_v[k]         = nv[k];
                cur_d[k*W +: W]  = nd[k*W +: W];
            end
        end
        bus0.i_valid = cur_v;
        bus0.i_data  = cur_d;
        bus0.o_ready = rdy;
        #1;
        occ = sb.size();
        g   = -1;
        for (int i = 0; i < CH; i++) begin
            c = (m_last + 1 + i) % CH;
            if (g < 0 && ((cur_v >> c) & 1) != 0) g = c;
        end
        exp_ready = (g >= 0 && occ < D) ? CH'(1 << g) : '0;
        last_ready = bus0.i_ready;
        check("i_ready", {28'd0, bus0.i_ready}, {28'd0, exp_ready});
        hold = cur_v;
        if (exp_ready != 0) begin
            hold[g] = 1'b0;
            m_last  = g;
            it.chan = 2'(g);
            it.data = cur_d[g*W +: W];
        end
        @(posedge clk);
        #1;
        if (exp_ready != 0) sb.push_back(it);
    endtask

    task automatic do_reset();
        bus0.i_valid = '0;
        bus0.o_ready = 1'b0;
        bus1.i_valid = '0;
        bus1.o_ready = 1'b0;
        cur_v = '0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_o_valid", {31'd0, bus0.o_valid}, 32'd0);
        sb.delete();
        hold   = '0;
        m_last = CH - 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_o_data", {24'd0, bus0.o_data}, 32'd0);
        check("rst_o_chan", {30'd0, bus0.o_chan}, 32'd0);
        check("rst_i_ready", {28'd0, bus0.i_ready}, 32'd0);
        check("rst1_o_valid", {31'd0, bus1.o_valid}, 32'd0);
        rst = 1'b0;
    endtask

    function automatic logic [CH*W-1:0] ramp_data(input int base);
        logic [CH*W-1:0] r;
        for (int k = 0; k < CH; k++) r[k*W +: W] = W'(base + k);
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        bus0.i_valid = '0;
        bus0.i_data  = '0;
        bus0.o_ready = 1'b0;
        bus1.i_valid = '0;
        bus1.i_data  = '0;
        bus1.o_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single word from channel 2
        step(4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}, 1'b1);
        check("single_ready", {28'd0, last_ready}, 32'h4);
        check("single_valid", {31'd0, bus0.o_valid}, 32'd1);
        check("single_data", {24'd0, bus0.o_data}, 32'hA5);
        check("single_chan", {30'd0, bus0.o_chan}, 32'd2);
        step('0, '0, 1'b1);
        check("single_empty", {31'd0, bus0.o_valid}, 32'd0);

        // Fairness with every channel valid
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step('1, ramp_data(8'h10), 1'b1);
            check("fair_ready", {28'd0, last_ready}, 32'(1 << (i % CH)));
        end
        for (int i = 0; i < 4; i++) step('0, '0, 1'b1);

        // Fill, backpressure, single pop
        do_reset();
        for (int i = 0; i < 4; i++) step('1, ramp_data(8'h20), 1'b0);
        step('1, ramp_data(8'h20), 1'b0);
        check("full_ready", {28'd0, last_ready}, 32'd0);
        step('1, ramp_data(8'h20), 1'b1);
        check("pop_no_push", {28'd0, last_ready}, 32'd0);
        step('1, ramp_data(8'h20), 1'b0);
        check("refill_ch0", {28'd0, last_ready}, 32'h1);

        // Simultaneous push and pop around the pointer wrap
        do_reset();
        step(4'b0010, ramp_data(8'h40), 1'b0);
        step(4'b0010, ramp_data(8'h50), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(CH'(1 << (i % CH)), ramp_data(8'h60 + 4 * i), 1'b1);
        end
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);

        // Reset with three words queued
        do_reset();
        step(4'b0001, ramp_data(8'h70), 1'b0);
        step(4'b0010, ramp_data(8'h74), 1'b0);
        step(4'b1000, ramp_data(8'h78), 1'b0);
        check("pre_rst_valid", {31'd0, bus0.o_valid}, 32'd1);
        do_reset();
        step('1, ramp_data(8'h80), 1'b1);
        check("post_rst_grant", {28'd0, last_ready}, 32'h1);
        for (int i = 0; i < 8; i++) step('0, '0, 1'b1);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [CH*W-1:0] rd;
            for (int k = 0; k < CH; k++) rd[k*W +: W] = W'($urandom);
            step(CH'($urandom), rd, ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 40 && (sb.size() != 0 || hold != 0); i++) step('0, '0, 1'b1);
        check("drain_empty", sb.size(), 32'd0);

        // Single-channel, depth-3 instance
        do_reset();
        for (int n = 0; n < 4; n++) begin
            bus1.i_valid = 1'b1;
            bus1.i_data  = W'(8'h30 + n);
            #1;
            check("c1_ready", {31'd0, bus1.i_ready}, {31'd0, n < 3});
            @(posedge clk);
            #1;
            check("c1_valid", {31'd0, bus1.o_valid}, 32'd1);
            check("c1_data", {24'd0, bus1.o_data}, 32'h30);
            check("c1_chan", {31'd0, bus1.o_chan}, 32'd0);
`ifdef RR_STREAM_MUX_LEVEL_EN
            check("c1_level", {30'd0, bus1.o_level}, (n < 3) ? n + 1 : 3);
            check("c1_full", {31'd0, bus1.o_full}, {31'd0, n >= 2});
            check("c1_stall", {31'd0, bus1.o_stall_seen}, {31'd0, n == 3});
`endif
        end
        repeat (3) @(posedge clk);
        #1;
        check("c1_still_full", {31'd0, bus1.i_ready}, 32'd0);
`ifdef RR_STREAM_MUX_LEVEL_EN
        check("c1_stall_sticky", {31'd0, bus1.o_stall_seen}, 32'd1);
`endif
        do_reset();
`ifdef RR_STREAM_MUX_LEVEL_EN
        check("c1_stall_cleared", {31'd0, bus1.o_stall_seen}, 32'd0);
        check("c1_level_cleared", {30'd0, bus1.o_level}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
